seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan controller for the 4-digit common-anode seven-segment display on the Nexys3 board. It time-multiplexes four hex digits onto the shared seg/an lines using a programmable slot timer. Each slot inserts a blanking interval to suppress ghosting. New display contents go through a load/ack handshake and are applied only at frame boundaries, so a frame never shows a torn value. It sits between any value producer (counters, debug registers) and the board pins.

Parameters:
PRESCALE, 50000, myclk cycles per digit slot (blank plus drive); minimum 4.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < PRESCALE.

Ports:
myclk  in  1  system clock; all logic is rising-edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  1 = scanning, 0 = display dark.
value  in  16  four hex nibbles; value[3:0] is digit 0 (an[0], rightmost).
dig_en  in  4  per-digit enable; 0 = that digit stays dark for its slot.
dp_en  in  4  per-digit decimal point; 1 = dp lit.
load  in  1  request to capture value/dig_en/dp_en; held high until load_ack.
load_ack  out  1  one-cycle pulse; the capture has taken effect.
seg  out  8  active-low segments; bit7..bit1 = a..g, bit0 = dp.
an  out  4  active-low anode selects.
frame_done  out  1  one-cycle pulse on the last cycle of digit 3's slot.

Behaviour:
- Reset (async assert, sync release):
  - an=4'b1111, seg=8'hFF, load_ack=0, frame_done=0.
  - Shadow value=0, dig_en=0, dp_en=0.
  - State OFF, digit index 0, slot counter 0.
- All outputs are registered. Outputs change one cycle after the state or counter that selects them.
- States:
  - OFF: an=1111, seg=FF. Go to BLANK (digit 0, counter 0) the cycle after enable=1.
  - BLANK: an=1111, seg=FF for BLANK_CYC cycles, then go to DRIVE.
  - DRIVE: lasts PRESCALE-BLANK_CYC cycles.
    - an = one-hot-low of the digit index.
    - seg = font(nibble) with bit0 = ~dp_en[idx].
    - If shadow dig_en[idx]=0: an=1111 and seg=FF, but slot timing is unchanged (uniform brightness).
    - At the end of the slot: idx <= idx+1 (mod 4), go to BLANK.
- Slot counter:
  - Counts 0..PRESCALE-1 and wraps. Width is clog2(PRESCALE).
  - The BLANK/DRIVE split is decided by comparing the counter with BLANK_CYC.
- One frame = 4*PRESCALE cycles. frame_done pulses when idx=3 and counter=PRESCALE-1.
- Font, active low (a..g, dp=1):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71
- Load handshake:
  - Capture occurs on the frame-boundary cycle (the frame_done cycle), or on any cycle in OFF, when load=1 and load_ack was 0 in the previous cycle.
  - load_ack pulses the cycle after capture. The new contents are displayed from digit 0's next DRIVE.
  - The requester drops load in the cycle it sees load_ack. Inputs are sampled only at capture.
  - A load asserted mid-frame waits, with worst-case latency 4*PRESCALE+1 cycles.
- enable dropped mid-slot:
  - Next cycle state=OFF with outputs dark. idx and counter reset to 0.
  - A pending load is then captured in OFF.
  - frame_done does not pulse for the aborted frame.
- frame_done and capture in the same cycle is normal: both happen.
- Reset mid-frame: immediate dark outputs; shadow cleared; any in-flight load is lost (the requester re-issues it).

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK=8'hFF and AN_OFF=4'hF;
  - the state enum {OFF, BLANK, DRIVE};
  - the 16-entry font constant table.
- Sub-module seg_hex_font: combinational nibble to 7-bit active-low pattern. It is instantiated once, after the digit mux.

Test Plan:
Use PRESCALE=8, BLANK_CYC=2 unless stated.
1. Reset then enable=1 with no load -> an stays 1111 and seg stays FF for the whole frame; frame_done pulses every 32 cycles.
2. In OFF, load value=16'h1234, dig_en=F, dp_en=0 -> load_ack one cycle after capture; after enable, digit 0 DRIVE gives an=1110, seg=99 (4) for 6 cycles after 2 blank cycles; then an=1101 seg=0D, an=1011 seg=25, an=0111 seg=9F.
3. Mid-frame load of 16'hABCD while scanning -> no load_ack before frame_done; ack one cycle after it; the next frame shows digit 0 seg=85 (d).
4. dig_en=4'b1010, dp_en=4'b0010 with 16'h0000 -> digits 0 and 2 dark for full slots; digit 1 seg=02 (0 with dp); digit 3 seg=03; frame period still 32.
5. Deassert enable during digit 2 DRIVE -> next cycle an=1111, seg=FF, no frame_done; re-enable restarts at digit 0 BLANK.
6. Assert rst_n=0 asynchronously mid-DRIVE, between clock edges -> an=1111 and seg=FF immediately; shadow cleared; load_ack=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
//   SEG_BLANK / AN_OFF : dark pattern for segment and anode lines (active low)
//   scan_state_e       : scan controller states
//   disp_cfg_t         : display contents held between frames
//   FONT               : hex font, active low, a..g in bits 7..1, dp (off) in bit 0
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    DRIVE
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [3:0]  dp_en;
  } disp_cfg_t;

  // Entry n sits at FONT[n]; listed from F down to 0.
  localparam logic [15:0][7:0] FONT = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

endpackage

// File: rtl/seg_hex_font.sv
// Hex nibble to active-low seven-segment pattern (a..g, MSB = a).
//   nibble    : hex digit to display
//   pattern_c : combinational segment pattern, dp not included
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern_c
);

  assign pattern_c = FONT[nibble][7:1];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
//   myclk, rst_n        : clock, async active-low reset
//   enable              : 1 = scan, 0 = display dark
//   value/dig_en/dp_en  : new display contents, taken on a load capture
//   load, load_ack      : capture request / one-cycle capture acknowledge
//   seg, an             : active-low segment and anode lines
//   frame_done          : one-cycle pulse on the last cycle of digit 3's slot
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        myclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_en,
  input  logic        load,
  output logic        load_ack,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  scan_state_e   state, state_d;
  logic [1:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  disp_cfg_t     shadow, shadow_d;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;
  logic          ack_d, fd_d;
  logic          boundary, capture;
  logic [3:0]    nib;
  logic [6:0]    pattern;

  // Digit mux ahead of the single font decoder.
  assign nib = shadow.value[{idx, 2'b00} +: 4];

  seg_hex_font u_font (
    .nibble    (nib),
    .pattern_c (pattern)
  );

  // State register plus registered outputs.
  always_ff @(posedge myclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= 2'd0;
      cnt        <= '0;
      shadow     <= '0;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      shadow     <= shadow_d;
      seg        <= seg_d;
      an         <= an_d;
      load_ack   <= ack_d;
      frame_done <= fd_d;
    end
  end

  // Next-state, slot timing, load capture and output selection.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt;
    shadow_d = shadow;
    seg_d    = SEG_BLANK;
    an_d     = AN_OFF;
    ack_d    = 1'b0;
    fd_d     = 1'b0;

    boundary = (state != OFF) && (idx == 2'd3) && (cnt == CNT_LAST);
    // load_ack high means this request was just served; ignore its tail.
    capture  = load && !load_ack && ((state == OFF) || boundary);

    if (capture) begin
      shadow_d = '{value: value, dig_en: dig_en, dp_en: dp_en};
    end
    ack_d = capture;

    if (!enable) begin
      state_d = OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (state == OFF) begin
      state_d = BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      fd_d = boundary;
      if (cnt == CNT_LAST) begin
        cnt_d   = '0;
        idx_d   = idx + 2'd1;
        state_d = BLANK;
      end else begin
        cnt_d   = cnt + CW'(1);
        state_d = (cnt_d < CNT_BLANK) ? BLANK : DRIVE;
      end
      // Disabled digits keep their slot time but stay dark.
      if ((state == DRIVE) && shadow.dig_en[idx]) begin
        an_d  = ~(4'b0001 << idx);
        seg_d = {pattern, ~shadow.dp_en[idx]};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned P      = 8;
  localparam int unsigned B      = 2;
  localparam int          NCYC   = 4000;
  localparam int          RST_AT = 2500;

  logic        myclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dig_en;
  logic [3:0]  dp_en;
  logic        load;
  logic        load_ack;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .myclk      (myclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .value      (value),
    .dig_en     (dig_en),
    .dp_en      (dp_en),
    .load       (load),
    .load_ack   (load_ack),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 myclk = ~myclk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the scan counted in cycles since scanning began.
  logic [7:0]  font_ref [16];
  bit          scanning;
  int          pos;
  logic [15:0] m_val;
  logic [3:0]  m_dig, m_dp;
  logic        e_ack, e_fd;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  int          no_load_until;

  task automatic model_reset();
    scanning = 0;
    pos      = 0;
    m_val    = '0;
    m_dig    = '0;
    m_dp     = '0;
    e_ack    = 1'b0;
    e_fd     = 1'b0;
    e_an     = 4'hF;
    e_seg    = 8'hFF;
  endtask

  // Expected outputs after the coming edge, given the inputs now applied.
  task automatic model_step();
    int d, c;
    bit bnd, cap;
    logic [3:0] nb;
    d   = (pos / P) % 4;
    c   = pos % P;
    bnd = scanning && ((pos % (4 * P)) == (4 * P - 1));
    cap = load && !e_ack && (!scanning || bnd);
    e_an  = 4'hF;
    e_seg = 8'hFF;
    if (enable && scanning && (c >= B) && m_dig[d]) begin
      nb    = m_val[4*d +: 4];
      e_an  = 4'hF;
      e_an[d] = 1'b0;
      e_seg = font_ref[nb];
      if (m_dp[d]) e_seg[0] = 1'b0;
    end
    e_fd  = enable && bnd;
    e_ack = cap;
    if (cap) begin
      m_val = value;
      m_dig = dig_en;
      m_dp  = dp_en;
    end
    if (!enable) begin
      scanning = 0;
      pos      = 0;
    end else if (!scanning) begin
      scanning = 1;
      pos      = 0;
    end else begin
      pos++;
    end
  endtask

  // Requester plus enable wander; first cycles load 1234 while dark.
  task automatic drive(input int i);
    if (i < 10) enable = 1'b0;
    else if (i == 10) enable = 1'b1;
    else if (enable) enable = ($urandom_range(0, 299) != 0);
    else enable = ($urandom_range(0, 7) == 0);

    if (load && e_ack) begin
      load = 1'b0;
    end else if (i == 2) begin
      load   = 1'b1;
      value  = 16'h1234;
      dig_en = 4'hF;
      dp_en  = 4'h0;
    end else if (!load && (i > no_load_until) && ($urandom_range(0, 39) == 0)) begin
      load   = 1'b1;
      value  = 16'($urandom);
      dig_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      dp_en  = 4'($urandom);
    end
  endtask

  initial begin
    font_ref = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    value  = '0;
    dig_en = '0;
    dp_en  = '0;
    no_load_until = 2;
    model_reset();
    repeat (2) @(negedge myclk);
    check_eq("rst_an", 32'(an), 32'h0000_000F);
    check_eq("rst_seg", 32'(seg), 32'h0000_00FF);
    check_eq("rst_ack", 32'(load_ack), 32'h0);
    check_eq("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    drive(0);
    model_step();
    for (int i = 1; i < NCYC; i++) begin
      @(negedge myclk);
      check_eq("an", 32'(an), 32'(e_an));
      check_eq("seg", 32'(seg), 32'(e_seg));
      check_eq("load_ack", 32'(load_ack), 32'(e_ack));
      check_eq("frame_done", 32'(frame_done), 32'(e_fd));
      if (i == RST_AT) begin
        @(posedge myclk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_an", 32'(an), 32'h0000_000F);
        check_eq("arst_seg", 32'(seg), 32'h0000_00FF);
        check_eq("arst_ack", 32'(load_ack), 32'h0);
        check_eq("arst_fd", 32'(frame_done), 32'h0);
        @(negedge myclk);
        rst_n = 1'b1;
        load  = 1'b0;
        model_reset();
        no_load_until = i + 80;
      end
      drive(i);
      model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
